ecc_enc_arbiter: RTL and testbench
==================================

ECC_ENC_ARBITER -- requirements
Module: ecc_enc_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the per-source grant counters.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  requester A offers a word.
REQ-005 a_data  input  64  requester A data word.
REQ-006 a_ready  output  1  A word accepted on a_valid&&a_ready.
REQ-007 b_valid / b_data / b_ready: same as REQ-004..006, for requester B.
REQ-008 out_valid  output  1  output register holds a codeword.
REQ-009 out_ready  input  1  consumer accepts on out_valid&&out_ready.
REQ-010 out_data  output  64  registered data word.
REQ-011 out_check  output  7  registered Hamming check bits for out_data.
REQ-012 out_src  output  1  source of the held word (0=A, 1=B).
REQ-013 a_count, b_count  output  CNT_W each  accepted-word counts per source.

Function
REQ-014 The block shall contain one combinational check-bit encoder, shared by A and B.
REQ-015 Encoder mapping: D[i]=data bit i-1, i=1..64; each D[i] takes the i-th non-power-of-two position in codeword positions 1..71, so D1->3, D4->7, D11->15, D26->31, D57->63, D58->65, D64->71.
REQ-016 check[k] (k=0..6) shall be the XOR of all D[i] whose codeword position has bit k set.
REQ-017 The FSM shall have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 Accept-enable: accept_en = EMPTY || (FULL && out_ready); a_ready and b_ready shall be 0 whenever accept_en is 0.
REQ-019 At most one requester shall be granted per cycle.
REQ-020 With accept_en=1 and only one valid, that requester shall be granted.
REQ-021 With accept_en=1 and both valid, the requester named by the priority pointer shall be granted.
REQ-022 ready shall be 1 only for the granted requester and shall not depend on that requester's own valid.
REQ-023 ready shall be combinational from the valid inputs, out_ready and state.
REQ-024 Priority pointer: after any grant it shall point to the non-granted source; with no grant it shall hold.
REQ-025 On a grant, the next edge shall load out_data, out_check and out_src, and the FSM shall enter FULL (one-cycle latency).
REQ-026 FULL && out_ready with no new grant shall return the FSM to EMPTY.
REQ-027 FULL && out_ready with a new grant shall drain and load in the same cycle; the FSM stays FULL, giving full throughput with no bubble.
REQ-028 FULL && !out_ready shall hold out_data, out_check, out_src and out_valid stable, and grant nobody.
REQ-029 a_count/b_count shall increment by 1 on each accepted word from that source.
REQ-030 Counters shall wrap from 2^CNT_W-1 to 0 with no saturation or flag.

Reset
REQ-031 resetn=0 shall asynchronously force: state EMPTY, out_valid=0, out_data=0, out_check=0, out_src=0, counters=0, priority pointer=A.
REQ-032 a_ready and b_ready shall be 0 while resetn=0.
REQ-033 Reset asserted mid-transfer shall discard any held codeword; it shall never be presented after reset release.
REQ-034 The first grant after reset release shall be on the first edge with resetn=1.

Verification
REQ-035 Reset, then A sends 64'h1, out_ready=1 -> next cycle out_valid=1, out_data=64'h1, out_check=7'h03, out_src=0, a_count=1.
REQ-036 B sends 64'h8000_0000_0000_0000 -> out_check=7'h47, out_src=1.
REQ-037 A and B valid continuously, out_ready=1 -> grants alternate A,B,A,B starting with A; out_valid stays 1 with no bubble; counts equal after even cycles.
REQ-038 out_ready=0 for 5 cycles while FULL -> a_ready=b_ready=0 and outputs stable; out_ready=1 -> drain plus next load in the same cycle.
REQ-039 Random 10k words checked against a reference Hamming model with backpressure -> no loss, no duplication, per-source order preserved, counters match.
REQ-040 resetn pulsed low while FULL -> out_valid=0 immediately, counters=0, next grant goes to A.

Source files
------------

// File: rtl/ecc_enc_arbiter_if.sv
// Handshake bundle for ecc_enc_arbiter: two 64-bit requesters (A, B) on the
// input side, one Hamming-encoded word on the output side, plus per-source
// accepted-word counters.
interface ecc_enc_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             a_valid;
    logic [63:0]      a_data;
    logic             a_ready;
    logic             b_valid;
    logic [63:0]      b_data;
    logic             b_ready;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [6:0]       out_check;
    logic             out_src;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_check, out_src,
               a_count, b_count
    );

    // Requester/consumer side.
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_check, out_src,
               a_count, b_count
    );
endinterface

// File: rtl/ecc_enc_arbiter.sv
// Two-source round-robin arbiter feeding one shared Hamming check-bit encoder.
// The granted word and its 7 check bits are captured in a single output
// register; a grant may drain and reload that register in the same cycle,
// so back-to-back traffic flows with no bubble.
module ecc_enc_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic                clock,
    input  logic                resetn,
    ecc_enc_arbiter_if.slave    io_bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_prio_b;     // 1: B wins a tie next time
    logic [63:0]      r_data;
    logic [6:0]       r_check;
    logic             r_src;
    logic [CNT_W-1:0] r_a_cnt;
    logic [CNT_W-1:0] r_b_cnt;

    logic             w_accept_en;
    logic             w_sel_b;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_grant;
    logic [63:0]      w_data;
    logic [6:0]       w_check;

    // Check bits: data bits fill the non-power-of-two codeword positions
    // 3,5,6,7,9,...,71 in order; every set data bit contributes its position
    // number, so check[k] collects all data bits whose position has bit k set.
    function automatic logic [6:0] f_encode(input logic [63:0] d);
        logic [6:0] chk;
        logic [6:0] pos;
        logic [5:0] di;
        chk = '0;
        di  = '0;
        for (int p = 1; p < 72; p++) begin
            pos = 7'(p);
            if ((pos & (pos - 7'd1)) != 7'd0) begin
                chk = chk ^ (pos & {7{d[di]}});
                di  = di + 6'd1;
            end
        end
        return chk;
    endfunction

    // Arbitration: pick at most one source, ready is the pick gated by accept_en.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here, by
        // assigning all of them unconditionally) so no latch is inferred.
        w_accept_en = resetn && ((r_state == EMPTY) || io_bus.out_ready);
        w_sel_b     = io_bus.b_valid && (!io_bus.a_valid || r_prio_b);
        w_grant_a   = w_accept_en && !w_sel_b && io_bus.a_valid;
        w_grant_b   = w_accept_en &&  w_sel_b;
        w_grant     = w_grant_a || w_grant_b;
    end

    assign w_data = w_sel_b ? io_bus.b_data : io_bus.a_data;

    // Shared encoder for whichever source is selected this cycle.
    always_comb begin
        w_check = f_encode(w_data);
    end

    // Output register FSM, priority pointer and per-source counters.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (!resetn) begin
            // NOTE: the output data register is reset too, because a held
            // codeword must never reappear after reset.
            r_state  <= EMPTY;
            r_prio_b <= 1'b0;
            r_data   <= '0;
            r_check  <= '0;
            r_src    <= 1'b0;
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
        end else begin
            if (w_grant) begin
                r_data   <= w_data;
                r_check  <= w_check;
                r_src    <= w_grant_b;
                r_prio_b <= w_grant_a;
                r_state  <= FULL;
            end else if ((r_state == FULL) && io_bus.out_ready) begin
                r_state  <= EMPTY;
            end

            if (w_grant_a) begin
                r_a_cnt <= r_a_cnt + CNT_W'(1);
            end
            if (w_grant_b) begin
                r_b_cnt <= r_b_cnt + CNT_W'(1);
            end
        end
    end

    assign io_bus.a_ready   = w_accept_en && !w_sel_b;
    assign io_bus.b_ready   = w_accept_en &&  w_sel_b;
    assign io_bus.out_valid = (r_state == FULL);
    assign io_bus.out_data  = r_data;
    assign io_bus.out_check = r_check;
    assign io_bus.out_src   = r_src;
    assign io_bus.a_count   = r_a_cnt;
    assign io_bus.b_count   = r_b_cnt;

endmodule

// File: tb/tb_ecc_enc_arbiter.sv
// Bench for ecc_enc_arbiter: directed vector table, hand-written sequences for
// round-robin, backpressure and mid-transfer reset, then a long randomized run
// checked against a queue-based reference with a codeword-level Hamming model.
module tb_ecc_enc_arbiter;

    localparam int CNT_W = 16;

    logic clock;
    logic resetn;

    ecc_enc_arbiter_if #(.CNT_W(CNT_W)) bus ();

    ecc_enc_arbiter #(.CNT_W(CNT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .io_bus (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder: lay the data out as a 71-bit codeword, then compute
    // each parity bit as the XOR of the codeword positions it covers.
    function automatic logic [6:0] ref_check(input logic [63:0] d);
        logic [127:0] cw;
        logic [5:0]   j;
        logic [6:0]   pp;
        logic [6:0]   chk;
        cw = '0;
        j  = '0;
        for (int p = 1; p < 72; p++) begin
            pp = 7'(p);
            if ($countones(pp) != 1) begin
                cw[pp] = d[j];
                j++;
            end
        end
        chk = '0;
        for (int k = 0; k < 7; k++) begin
            for (int p = 1; p < 72; p++) begin
                pp = 7'(p);
                if (pp[3'(k)] && cw[pp]) chk[3'(k)] = ~chk[3'(k)];
            end
        end
        return chk;
    endfunction

    // ---------------- reference model / monitor for the random run --------
    logic        mon_en = 1'b0;
    logic        took_a = 1'b0;
    logic        took_b = 1'b0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic        m_full;
    logic        m_turn_b;
    int          cnt_a, cnt_b, consumed;

    // Each falling edge: predict the grant from the handshake rules, check
    // outputs against the per-source queues, then advance the model.
    always @(negedge clock) begin
        logic        ga, gb, en, ea, eb;
        logic [63:0] w;
        if (!mon_en) begin
            qa.delete();
            qb.delete();
            m_full   = 1'b0;
            m_turn_b = 1'b0;
            cnt_a    = 0;
            cnt_b    = 0;
            consumed = 0;
            took_a   = 1'b0;
            took_b   = 1'b0;
        end else begin
            ga = bus.a_valid && bus.a_ready;
            gb = bus.b_valid && bus.b_ready;
            en = !m_full || bus.out_ready;
            ea = en && bus.a_valid && (!bus.b_valid || !m_turn_b);
            eb = en && bus.b_valid && (!bus.a_valid ||  m_turn_b);
            check("rnd_grant_a", 64'(ga), 64'(ea));
            check("rnd_grant_b", 64'(gb), 64'(eb));
            check("rnd_out_valid", 64'(bus.out_valid), 64'(m_full));
            check("rnd_a_count", 64'(bus.a_count), 64'(cnt_a & 'hFFFF));
            check("rnd_b_count", 64'(bus.b_count), 64'(cnt_b & 'hFFFF));
            if (!en) begin
                check("rnd_ready_blocked", {62'd0, bus.a_ready, bus.b_ready}, 64'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if ((bus.out_src ? qb.size() : qa.size()) == 0) begin
                    check("rnd_unexpected_word", 64'd1, 64'd0);
                end else begin
                    w = bus.out_src ? qb.pop_front() : qa.pop_front();
                    check("rnd_out_data", bus.out_data, w);
                    check("rnd_out_check", 64'(bus.out_check), 64'(ref_check(w)));
                end
                consumed++;
            end
            if (ea) begin
                qa.push_back(bus.a_data);
                cnt_a++;
                m_turn_b = 1'b1;
            end
            if (eb) begin
                qb.push_back(bus.b_data);
                cnt_b++;
                m_turn_b = 1'b0;
            end
            m_full = ea || eb || (m_full && !bus.out_ready);
            took_a = ga;
            took_b = gb;
        end
    end

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic        av;
        logic [63:0] ad;
        logic        bv;
        logic [63:0] bd;
        logic        src;
        logic [63:0] data;
        logic [6:0]  chk;
        int          acnt;
        int          bcnt;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        resetn        = 1'b0;
        bus.a_valid   = 1'b0;
        bus.b_valid   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    localparam logic [63:0] A_WORD = 64'hAAAA_0000_1234_5678;
    localparam logic [63:0] B_WORD = 64'hBBBB_0000_8765_4321;

    initial begin
        int cyc;
        resetn        = 1'b0;
        bus.a_valid   = 1'b0;
        bus.a_data    = '0;
        bus.b_valid   = 1'b0;
        bus.b_data    = '0;
        bus.out_ready = 1'b0;

        //                  av    ad                      bv    bd                      src   data                    chk    a  b
        vecs[0] = '{1'b1, 64'h1,                  1'b0, 64'h0,                  1'b0, 64'h1,                  7'h03, 1, 0};
        vecs[1] = '{1'b0, 64'h0,                  1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 7'h47, 1, 1};
        vecs[2] = '{1'b1, 64'h2,                  1'b1, 64'h8,                  1'b0, 64'h2,                  7'h05, 2, 1};
        vecs[3] = '{1'b1, 64'h400,                1'b1, 64'h200_0000,           1'b1, 64'h200_0000,           7'h1F, 2, 2};
        vecs[4] = '{1'b0, 64'h0,                  1'b1, 64'h0100_0000_0000_0000, 1'b1, 64'h0100_0000_0000_0000, 7'h3F, 2, 3};
        vecs[5] = '{1'b1, 64'h0200_0000_0000_0000, 1'b0, 64'h0,                  1'b0, 64'h0200_0000_0000_0000, 7'h41, 3, 3};
        vecs[6] = '{1'b1, 64'h3,                  1'b0, 64'h0,                  1'b0, 64'h3,                  7'h06, 4, 3};
        vecs[7] = '{1'b0, 64'h0,                  1'b1, 64'h0,                  1'b1, 64'h0,                  7'h00, 4, 4};

        // Reset state, with requesters and consumer active to prove ready is held low.
        repeat (2) @(posedge clock);
        #1;
        bus.a_valid   = 1'b1;
        bus.b_valid   = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_check", 64'(bus.out_check), 64'd0);
        check("rst_out_src", 64'(bus.out_src), 64'd0);
        check("rst_counts", {32'(bus.a_count), 32'(bus.b_count)}, 64'd0);
        check("rst_ready", {62'd0, bus.a_ready, bus.b_ready}, 64'd0);
        do_reset();

        // Single-word transactions from EMPTY, one-cycle latency each.
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            bus.a_valid   = vecs[i].av;
            bus.a_data    = vecs[i].ad;
            bus.b_valid   = vecs[i].bv;
            bus.b_data    = vecs[i].bd;
            bus.out_ready = 1'b1;
            @(posedge clock);
            #1;
            bus.a_valid = 1'b0;
            bus.b_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d_out_src", i), 64'(bus.out_src), 64'(vecs[i].src));
            check($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].data);
            check($sformatf("vec%0d_out_check", i), 64'(bus.out_check), 64'(vecs[i].chk));
            check($sformatf("vec%0d_a_count", i), 64'(bus.a_count), 64'(vecs[i].acnt));
            check($sformatf("vec%0d_b_count", i), 64'(bus.b_count), 64'(vecs[i].bcnt));
            @(posedge clock);
        end
        #1;
        check("vec_drained", 64'(bus.out_valid), 64'd0);

        // Both requesters streaming: A,B,A,B... with no bubble.
        do_reset();
        @(posedge clock);
        #1;
        bus.a_valid   = 1'b1;
        bus.a_data    = A_WORD;
        bus.b_valid   = 1'b1;
        bus.b_data    = B_WORD;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rr%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("rr%0d_out_src", i), 64'(bus.out_src), 64'(i % 2));
            check($sformatf("rr%0d_out_data", i), bus.out_data, (i % 2 == 0) ? A_WORD : B_WORD);
        end
        check("rr_counts", {32'(bus.a_count), 32'(bus.b_count)}, {32'd4, 32'd4});

        // Backpressure for 5 cycles while holding B's word.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("bp%0d_ready", i), {62'd0, bus.a_ready, bus.b_ready}, 64'd0);
            check($sformatf("bp%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp%0d_out_data", i), bus.out_data, B_WORD);
            check($sformatf("bp%0d_out_check", i), 64'(bus.out_check), 64'(ref_check(B_WORD)));
            check($sformatf("bp%0d_counts", i), {32'(bus.a_count), 32'(bus.b_count)}, {32'd4, 32'd4});
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_release_out_src", 64'(bus.out_src), 64'd0);
        check("bp_release_out_data", bus.out_data, A_WORD);
        check("bp_release_counts", {32'(bus.a_count), 32'(bus.b_count)}, {32'd5, 32'd4});

        // Reset pulse while FULL; the held word is dropped, A wins next.
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_counts", {32'(bus.a_count), 32'(bus.b_count)}, 64'd0);
        check("mid_rst_ready", {62'd0, bus.a_ready, bus.b_ready}, 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst_out_src", 64'(bus.out_src), 64'd0);
        check("post_rst_out_data", bus.out_data, A_WORD);
        check("post_rst_counts", {32'(bus.a_count), 32'(bus.b_count)}, {32'd1, 32'd0});

        // Randomized run with backpressure against the reference model.
        do_reset();
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        cyc = 0;
        while (cyc < 40000 && consumed < 10000) begin
            if (!bus.a_valid || took_a) begin
                bus.a_valid = ($urandom_range(0, 3) != 0);
                bus.a_data  = {$urandom, $urandom};
            end
            if (!bus.b_valid || took_b) begin
                bus.b_valid = ($urandom_range(0, 3) != 0);
                bus.b_data  = {$urandom, $urandom};
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock);
            #1;
            cyc++;
        end
        check("rnd_budget", 64'(consumed >= 10000), 64'd1);
        bus.a_valid   = 1'b0;
        bus.b_valid   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        #1;
        check("rnd_qa_empty", 64'(qa.size()), 64'd0);
        check("rnd_qb_empty", 64'(qb.size()), 64'd0);
        check("rnd_consumed", 64'(consumed), 64'(cnt_a + cnt_b));
        check("rnd_final_a_count", 64'(bus.a_count), 64'(cnt_a & 'hFFFF));
        check("rnd_final_b_count", 64'(bus.b_count), 64'(cnt_b & 'hFFFF));
        check("rnd_final_empty", 64'(bus.out_valid), 64'd0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
